// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that multiplexes NREQ write requesters onto one FIFO write port,
// handing the port to one owner for up to BURST words per grant.
module fifo_wr_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int BURST = 4
) (
    input  logic                  clk_i,
    input  logic                  clr_i,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*WIDTH-1:0] wdata_i,
    input  logic                  full_i,
    output logic [NREQ-1:0]       gnt_o,
    output logic [NREQ-1:0]       ack_o,
    output logic                  wr_en_o,
    output logic [WIDTH-1:0]      wdata_o,
    output logic                  busy_o
);
    localparam int OW = $clog2(NREQ);
    localparam int CW = $clog2(BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state;
    logic [OW-1:0] owner;
    logic [OW-1:0] last_owner;
    logic [CW-1:0] cnt;
    logic [OW-1:0] pick;
    logic          found;
    logic [OW:0]   scan;
    logic          accept;

    // Search starts just past the previous owner so a persistent requester goes to the back.
    always_comb begin
        pick  = last_owner;
        found = 1'b0;
        scan  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            scan = {1'b0, last_owner} + (OW+1)'(i);
            if (scan >= (OW+1)'(NREQ))
                scan = scan - (OW+1)'(NREQ);
            if (!found && req_i[scan[OW-1:0]]) begin
                found = 1'b1;
                pick  = scan[OW-1:0];
            end
        end
    end

    assign accept  = (state == GRANT) && req_i[owner] && !full_i;
    assign wr_en_o = accept;
    assign wdata_o = accept ? wdata_i[owner*WIDTH +: WIDTH] : '0;
    assign busy_o  = (state == GRANT);

    always_comb begin
        ack_o        = '0;
        ack_o[owner] = accept;
    end

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= OW'(NREQ - 1);
            cnt        <= '0;
            gnt_o      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state      <= GRANT;
                        owner      <= pick;
                        last_owner <= pick;
                        cnt        <= '0;
                        gnt_o      <= NREQ'(1) << pick;
                    end
                end
                GRANT: begin
                    // A dropped request releases even while the FIFO is full.
                    if (!req_i[owner]) begin
                        state <= IDLE;
                        gnt_o <= '0;
                    end else if (accept) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(BURST - 1)) begin
                            state <= IDLE;
                            gnt_o <= '0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt_o <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, directed corner sequences, and random traffic
// compared against a transaction-level round-robin model.
module tb_fifo_wr_arbiter;
    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int BURST = 4;

    logic                  clk = 1'b0;
    logic                  clr_i = 1'b1;
    logic [NREQ-1:0]       req_i = '0;
    logic [NREQ*WIDTH-1:0] wdata_i = '0;
    logic                  full_i = 1'b0;
    logic [NREQ-1:0]       gnt_o, ack_o;
    logic                  wr_en_o;
    logic [WIDTH-1:0]      wdata_o;
    logic                  busy_o;

    fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .BURST(BURST)) dut (
        .clk_i(clk), .clr_i(clr_i), .req_i(req_i), .wdata_i(wdata_i), .full_i(full_i),
        .gnt_o(gnt_o), .ack_o(ack_o), .wr_en_o(wr_en_o), .wdata_o(wdata_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            clr;
        logic [NREQ-1:0] req;
        logic            full;
        logic [7:0]      d0;
        logic [NREQ-1:0] gnt;
        logic            wr;
        logic [NREQ-1:0] ack;
        logic [7:0]      wd;
        logic            busy;
    } vec_t;

    vec_t tbl[9];
    int n_pass = 0, n_total = 0;
    int m_own, m_last, m_taken;
    int order[$], acks[$], gaps[$];
    int gap, nw;
    bit rel;
    logic [NREQ-1:0]  prev, e_gnt, e_ack;
    logic             e_wr;
    logic [WIDTH-1:0] e_wd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int oh2i(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        clr_i = 1'b1; req_i = '0; full_i = 1'b0;
        @(negedge clk);
        clr_i = 1'b0;
    endtask

    // Counts words accepted under grant g until the grant drops (bounded).
    task automatic count_words(input logic [NREQ-1:0] g, output int n, output bit released);
        n = 0; released = 0;
        for (int t = 0; t < 12; t++) begin
            #1;
            if (gnt_o == '0) begin released = 1; break; end
            if (gnt_o == g && ack_o == g && wr_en_o) n++;
            @(negedge clk);
        end
    endtask

    task automatic m_reset();
        m_own = -1; m_last = NREQ - 1; m_taken = 0;
    endtask

    task automatic m_step();
        if (clr_i) m_reset();
        else if (m_own < 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (m_last + k) % NREQ;
                if (req_i[c]) begin m_own = c; m_last = c; m_taken = 0; break; end
            end
        end else if (!req_i[m_own]) m_own = -1;
        else if (!full_i) begin
            m_taken++;
            if (m_taken == BURST) m_own = -1;
        end
    endtask

    initial begin
        // clr, req, full, d0 | gnt, wr, ack, wd, busy
        tbl[0] = '{1'b1, 4'hF, 1'b0, 8'h00, 4'h0, 1'b0, 4'h0, 8'h00, 1'b0};
        tbl[1] = '{1'b1, 4'hF, 1'b0, 8'h00, 4'h0, 1'b0, 4'h0, 8'h00, 1'b0};
        tbl[2] = '{1'b0, 4'h1, 1'b0, 8'hA0, 4'h0, 1'b0, 4'h0, 8'h00, 1'b0};
        tbl[3] = '{1'b0, 4'h1, 1'b0, 8'hA0, 4'h1, 1'b1, 4'h1, 8'hA0, 1'b1};
        tbl[4] = '{1'b0, 4'h1, 1'b0, 8'hA1, 4'h1, 1'b1, 4'h1, 8'hA1, 1'b1};
        tbl[5] = '{1'b0, 4'h1, 1'b0, 8'hA2, 4'h1, 1'b1, 4'h1, 8'hA2, 1'b1};
        tbl[6] = '{1'b0, 4'h1, 1'b0, 8'hA3, 4'h1, 1'b1, 4'h1, 8'hA3, 1'b1};
        tbl[7] = '{1'b0, 4'h1, 1'b0, 8'hA4, 4'h0, 1'b0, 4'h0, 8'h00, 1'b0};
        tbl[8] = '{1'b0, 4'h1, 1'b0, 8'hA5, 4'h1, 1'b1, 4'h1, 8'hA5, 1'b1};

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            clr_i = tbl[i].clr; req_i = tbl[i].req; full_i = tbl[i].full;
            wdata_i = {8'h33, 8'h22, 8'h11, tbl[i].d0};
            #1;
            chk($sformatf("vec%0d_gnt", i), gnt_o, tbl[i].gnt);
            chk($sformatf("vec%0d_wr", i), wr_en_o, tbl[i].wr);
            chk($sformatf("vec%0d_ack", i), ack_o, tbl[i].ack);
            chk($sformatf("vec%0d_wdata", i), wdata_o, tbl[i].wd);
            chk($sformatf("vec%0d_busy", i), busy_o, tbl[i].busy);
        end

        // Round-robin with everyone requesting
        do_reset();
        req_i = '1; wdata_i = 32'h44332211;
        gap = 0; prev = '0;
        for (int t = 0; t < 26; t++) begin
            #1;
            if (gnt_o != '0) begin
                if (prev == '0) begin
                    if (order.size() > 0) gaps.push_back(gap);
                    gap = 0;
                    order.push_back(oh2i(gnt_o));
                    acks.push_back(0);
                end
                if (wr_en_o && ack_o == gnt_o) acks[acks.size()-1] = acks[acks.size()-1] + 1;
            end else gap++;
            prev = gnt_o;
            @(negedge clk);
        end
        chk("rr_grant_count", order.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rr_order%0d", i), (i < order.size()) ? order[i] : -1, i % 4);
            chk($sformatf("rr_acks%0d", i), (i < acks.size()) ? acks[i] : -1, BURST);
        end
        for (int i = 0; i < 4; i++)
            chk($sformatf("rr_gap%0d", i), (i < gaps.size()) ? gaps[i] : -1, 1);

        // Stall for three cycles after the second word
        do_reset();
        req_i = 4'b0001;
        #1 chk("stall_idle_gnt", gnt_o, 4'b0000);
        @(negedge clk); #1 chk("stall_w1", wr_en_o, 1'b1);
        @(negedge clk); #1 chk("stall_w2", wr_en_o, 1'b1);
        for (int t = 0; t < 3; t++) begin
            @(negedge clk); full_i = 1'b1;
            #1;
            chk($sformatf("stall%0d_wr", t), wr_en_o, 1'b0);
            chk($sformatf("stall%0d_ack", t), ack_o, 4'b0000);
            chk($sformatf("stall%0d_gnt", t), gnt_o, 4'b0001);
        end
        @(negedge clk); full_i = 1'b0;
        count_words(4'b0001, nw, rel);
        chk("stall_remaining_words", nw, 2);
        chk("stall_released", rel, 1'b1);

        // Requester 0 drops after two words; requester 1 then gets a full burst
        do_reset();
        req_i = 4'b0011;
        #1 chk("drop_idle_gnt", gnt_o, 4'b0000);
        @(negedge clk); #1 chk("drop_w1", ack_o, 4'b0001);
        @(negedge clk); #1 chk("drop_w2", ack_o, 4'b0001);
        @(negedge clk); req_i = 4'b0010;
        #1 chk("drop_no_write", wr_en_o, 1'b0);
        @(negedge clk); #1 chk("drop_idle_gap", gnt_o, 4'b0000);
        @(negedge clk); #1 chk("drop_next_gnt", gnt_o, 4'b0010);
        count_words(4'b0010, nw, rel);
        chk("drop_next_words", nw, 4);
        chk("drop_next_released", rel, 1'b1);

        // Reset pulse in the middle of a burst
        do_reset();
        req_i = 4'b0100;
        @(negedge clk); #1 chk("mid_gnt", gnt_o, 4'b0100);
        chk("mid_w1", wr_en_o, 1'b1);
        @(negedge clk); #2 clr_i = 1'b1;
        #1;
        chk("mid_clr_gnt", gnt_o, 4'b0000);
        chk("mid_clr_wr", wr_en_o, 1'b0);
        chk("mid_clr_busy", busy_o, 1'b0);
        @(negedge clk); clr_i = 1'b0; req_i = 4'b0101;
        #1 chk("mid_rel_idle", gnt_o, 4'b0000);
        @(negedge clk); #1 chk("mid_rel_gnt", gnt_o, 4'b0001);

        // Random traffic against the reference model
        do_reset();
        m_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            clr_i = ($urandom_range(0, 99) == 0);
            for (int b = 0; b < NREQ; b++)
                if ($urandom_range(0, 7) == 0) req_i[b] = ~req_i[b];
            full_i = ($urandom_range(0, 3) == 0);
            wdata_i = $urandom();
            #1;
            if (clr_i) m_reset();
            e_gnt = '0; e_ack = '0; e_wr = 1'b0; e_wd = '0;
            if (m_own >= 0) begin
                e_gnt[m_own] = 1'b1;
                e_wr = req_i[m_own] && !full_i;
                if (e_wr) begin
                    e_ack[m_own] = 1'b1;
                    e_wd = wdata_i[m_own*WIDTH +: WIDTH];
                end
            end
            chk("rnd_gnt", gnt_o, e_gnt);
            chk("rnd_ack", ack_o, e_ack);
            chk("rnd_wr", wr_en_o, e_wr);
            chk("rnd_wdata", wdata_o, e_wd);
            chk("rnd_busy", busy_o, m_own >= 0);
            chk("rnd_wr_while_full", wr_en_o & full_i, 1'b0);
            m_step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
